md_sequencer: RTL and testbench

//  Iterative multiply/divide sequencer owning the HI/LO registers of the pipelined MIPS core.

---
 rtl/md_sequencer.sv | 149 ++++++++++++++
 tb/tb_md_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per RUN cycle,
// followed by a single FIX cycle for sign correction and the HI/LO write.
// Optional build macro: MDU_EARLY_OUT_EN lets multiplies leave RUN as soon
// as the remaining multiplier bits are all zero.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             flushE,
  input  logic [1:0]       mdopE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic [1:0]       hlwriteW,
  input  logic [WIDTH-1:0] hlwdataW,
  input  logic             mdreqD,
  output logic             busy,
  output logic             stallD,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               is_signed;
  logic               neg_a;
  logic               neg_b;
  logic               b_zero;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  logic               accept;
  logic               op_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               take;
  logic               last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && startE && !flushE;
  assign stallD = mdreqD && (busy || accept);

  // Operand magnitudes, one iteration of each datapath, and the sign-corrected results
  always_comb begin
    op_signed = !mdopE[0];
    abs_a     = (op_signed && srcaE[WIDTH-1]) ? (~srcaE + 1'b1) : srcaE;
    abs_b     = (op_signed && srcbE[WIDTH-1]) ? (~srcbE + 1'b1) : srcbE;
    rem_shift = {rem, quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb};
    take      = !rem_diff[WIDTH];
    last      = (count == '0);
`ifdef MDU_EARLY_OUT_EN
    if (!is_div && (opb[WIDTH-1:1] == '0)) last = 1'b1;
`endif
    prod_fix  = (is_signed && (neg_a ^ neg_b)) ? (~prod + 1'b1) : prod;
    quo_fix   = (is_signed && (neg_a ^ neg_b) && !b_zero) ? (~quo + 1'b1) : quo;
    rem_fix   = (is_signed && neg_a) ? (~rem + 1'b1) : rem;
    if (is_div) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Sequencer state machine, iteration datapath and HI/LO architectural registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      b_zero    <= 1'b0;
      mcand     <= '0;
      prod      <= '0;
      opb       <= '0;
      quo       <= '0;
      rem       <= '0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div    <= mdopE[1];
            is_signed <= op_signed;
            neg_a     <= op_signed && srcaE[WIDTH-1];
            neg_b     <= op_signed && srcbE[WIDTH-1];
            b_zero    <= (srcbE == '0);
            mcand     <= {{WIDTH{1'b0}}, abs_a};
            prod      <= '0;
            opb       <= abs_b;
            quo       <= abs_a;
            rem       <= '0;
            count     <= CW'(WIDTH - 1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            rem <= take ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], take};
          end else begin
            if (opb[0]) prod <= prod + mcand;
            mcand <= mcand << 1;
            opb   <= opb >> 1;
          end
          count <= count - 1'b1;
          if (last) begin
            state <= FIX;
            done  <= 1'b1;
          end
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (hlwriteW[1]) hi <= hlwdataW;
      if (hlwriteW[0]) lo <= hlwdataW;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: self-checking bench for md_sequencer with a behavioural
// reference model based on plain 64-bit arithmetic.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE;
  logic        flushE;
  logic [1:0]  mdopE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic [1:0]  hlwriteW;
  logic [31:0] hlwdataW;
  logic        mdreqD;
  logic        busy;
  logic        stallD;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checkCount = 0;
  int errorCount = 0;

  md_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .flushE(flushE), .mdopE(mdopE),
    .srcaE(srcaE), .srcbE(srcbE), .hlwriteW(hlwriteW), .hlwdataW(hlwdataW),
    .mdreqD(mdreqD), .busy(busy), .stallD(stallD), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference results straight from integer arithmetic rules
  task automatic modelOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
    logic [63:0]        up;
    logic signed [63:0] sp;
    int                 sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin
        sp = 64'(sa) * 64'(sb);
        eh = sp[63:32];
        el = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'd0;
        end else if (op == 2'b10) begin
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endtask

  // Expected number of cycles with busy high for one operation
  function automatic int expBusy(input logic [1:0] op, input logic [31:0] b);
    int n;
    logic [31:0] mag;
    n   = 32;
    mag = b;
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      if (op == 2'b00 && b[31]) mag = -b;
      n = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    end
`endif
    return n + 1;
  endfunction

  // Issue one mult/div with mdreqD held, then check timing, stall, done and results
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    int cycles, dones;
    modelOp(op, a, b, eh, el);
    @(negedge clk);
    startE = 1'b1; mdopE = op; srcaE = a; srcbE = b; mdreqD = 1'b1;
    #1 checkOutput({tag, " stall_accept"}, 64'(stallD), 64'd1);
    @(posedge clk); #1;
    startE = 1'b0;
    cycles = 0;
    dones  = 0;
    while (busy && cycles < 100) begin
      if (!stallD) checkOutput({tag, " stall_busy"}, 64'(stallD), 64'd1);
      if (done) dones++;
      cycles++;
      @(posedge clk); #1;
    end
    if (cycles >= 100) checkOutput({tag, " timeout"}, 64'd1, 64'd0);
    checkOutput({tag, " busy_cycles"}, 64'(cycles), 64'(expBusy(op, b)));
    checkOutput({tag, " done_pulses"}, 64'(dones), 64'd1);
    checkOutput({tag, " stall_idle"}, 64'(stallD), 64'd0);
    checkOutput({tag, " hi"}, 64'(hi), 64'(eh));
    checkOutput({tag, " lo"}, 64'(lo), 64'(el));
    mdreqD = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int dones, waitCount;

    reset = 1'b0; startE = 1'b0; flushE = 1'b0; mdopE = 2'b00;
    srcaE = '0; srcbE = '0; hlwriteW = 2'b00; hlwdataW = '0; mdreqD = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    applyStimulus(2'b00, -32'sd3, 32'd7, "mult_neg");
    applyStimulus(2'b10, -32'sd7, 32'd2, "div_neg");
    applyStimulus(2'b11, 32'd100, 32'd7, "divu");
    applyStimulus(2'b10, 32'd5, 32'd0, "div_zero");
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    applyStimulus(2'b01, 32'd9, 32'd1, "multu_9x1");
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    // flushed start must be ignored
    @(negedge clk);
    startE = 1'b1; flushE = 1'b1; mdopE = 2'b01; srcaE = 32'd4; srcbE = 32'd4;
    @(posedge clk); #1;
    startE = 1'b0; flushE = 1'b0;
    checkOutput("flush busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    checkOutput("flush busy2", 64'(busy), 64'd0);

    // reset in the middle of RUN abandons the operation
    @(negedge clk);
    startE = 1'b1; mdopE = 2'b01; srcaE = 32'h1234_5678; srcbE = 32'h0000_FFFF;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset hi", 64'(hi), 64'd0);
    checkOutput("midreset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checkOutput("midreset no_done", 64'(dones), 64'd0);

    // mthi in the FIX cycle wins for HI, LO takes the product
    @(negedge clk);
    startE = 1'b1; mdopE = 2'b01; srcaE = 32'd2; srcbE = 32'd3;
    @(posedge clk); #1;
    startE = 1'b0;
    waitCount = 0;
    while (!done && waitCount < 100) begin
      @(posedge clk); #1;
      waitCount++;
    end
    if (waitCount >= 100) checkOutput("fix_write timeout", 64'd1, 64'd0);
    hlwriteW = 2'b10; hlwdataW = 32'h0000_ABCD;
    @(posedge clk); #1;
    hlwriteW = 2'b00;
    checkOutput("fix_write hi", 64'(hi), 64'h0000_ABCD);
    checkOutput("fix_write lo", 64'(lo), 64'd6);
    checkOutput("fix_write busy", 64'(busy), 64'd0);

    // mtlo while idle
    @(negedge clk);
    hlwriteW = 2'b01; hlwdataW = 32'h5555_AAAA;
    @(posedge clk); #1;
    hlwriteW = 2'b00;
    checkOutput("mtlo lo", 64'(lo), 64'h5555_AAAA);
    checkOutput("mtlo hi", 64'(hi), 64'h0000_ABCD);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
